// File: rtl/exmem_stage.sv
// exmem_stage: pipeline register between execute and memory.
// Decodes the ALU opcode into memory and register-write controls,
// rewrites the result for jumps, and raises a one-cycle redirect for
// taken control flow.
// Build option: define EXMEM_SKID_EN for a two-entry skid buffer with a
// registered in_ready; leave it undefined for a single pipeline register
// whose in_ready depends combinationally on out_ready.
module exmem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_instruction,
    input  logic [63:0] in_result,
    input  logic [63:0] in_rs1,
    input  logic [63:0] in_rs2,
    input  logic [63:0] in_imm,
    input  logic [63:0] in_pc,
    input  logic [4:0]  in_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_instruction,
    output logic [63:0] out_result,
    output logic [63:0] out_store_data,
    output logic [4:0]  out_rd,
    output logic [63:0] out_pc,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic        out_reg_write,
    output logic        redirect_valid,
    output logic [63:0] redirect_target
);

    typedef struct packed {
        logic [7:0]  instr;
        logic [63:0] result;
        logic [63:0] storeData;
        logic [4:0]  rd;
        logic [63:0] pc;
        logic        memRead;
        logic        memWrite;
        logic        regWrite;
    } entry_t;

    entry_t      newEntry;
    entry_t      headEntry;
    logic        newTaken;
    logic [63:0] newTarget;
    logic        isStore;
    logic        isLoad;
    logic        isBranch;
    logic        isJal;
    logic        isJalr;
    logic        writesReg;
    logic        acceptEff;
    logic        leave;

    logic        redirectValid_q;
    logic [63:0] redirectTarget_q;

    // Decode the incoming opcode into the entry that will be stored.
    always_comb begin
        isStore   = in_instruction inside {[8'd43:8'd46]};
        isLoad    = in_instruction inside {[8'd59:8'd65]};
        isBranch  = in_instruction inside {[8'd47:8'd52]};
        isJal     = (in_instruction == 8'd53);
        isJalr    = (in_instruction == 8'd54);
        writesReg = (in_instruction <= 8'd42)
                  || (in_instruction inside {[8'd53:8'd56]})
                  || isLoad;

        newEntry           = '0;
        newEntry.instr     = in_instruction;
        newEntry.result    = (isJal || isJalr) ? (in_pc + 64'd4) : in_result;
        newEntry.storeData = isStore ? in_rs2 : 64'd0;
        newEntry.rd        = in_rd;
        newEntry.pc        = in_pc;
        newEntry.memRead   = isLoad;
        newEntry.memWrite  = isStore;
        newEntry.regWrite  = writesReg && (in_rd != 5'd0);

        newTaken  = isBranch ? in_result[0] : (isJal || isJalr);
        newTarget = isJalr ? ((in_rs1 + in_imm) & ~64'd1) : (in_pc + in_imm);
    end

    assign acceptEff = in_valid && in_ready && !flush;
    assign leave     = out_valid && out_ready;

    // Redirect pulses the cycle after a taken entry is accepted; flush cancels it.
    always_ff @(posedge clk) begin
        if (reset) begin
            redirectValid_q  <= 1'b0;
            redirectTarget_q <= 64'd0;
        end else begin
            redirectValid_q <= acceptEff && newTaken;
            if (acceptEff && newTaken) begin
                redirectTarget_q <= newTarget;
            end
        end
    end

`ifdef EXMEM_SKID_EN
    entry_t [1:0] slot_q;
    entry_t [1:0] slot_d;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         inReady_q;

    // Next-state of the two-entry queue: pop shifts slot 1 down, push fills the first free slot.
    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (leave) begin
                slot_d[0] = slot_q[1];
                count_d   = count_q - 2'd1;
            end
            if (acceptEff) begin
                slot_d[count_d[0]] = newEntry;
                count_d            = count_d + 2'd1;
            end
        end
    end

    // Queue storage, occupancy and the registered ready flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q    <= '0;
            count_q   <= 2'd0;
            inReady_q <= 1'b1;
        end else begin
            slot_q    <= slot_d;
            count_q   <= count_d;
            inReady_q <= (count_d < 2'd2);
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = (count_q != 2'd0);
    assign headEntry = slot_q[0];
`else
    entry_t entry_q;
    entry_t entry_d;
    logic   valid_q;
    logic   valid_d;

    // Next-state of the single register: flush empties, accept reloads, leave empties.
    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (acceptEff) begin
            entry_d = newEntry;
            valid_d = 1'b1;
        end else if (leave) begin
            valid_d = 1'b0;
        end
    end

    // Single pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= '0;
            valid_q <= 1'b0;
        end else begin
            entry_q <= entry_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign headEntry = entry_q;
`endif

    assign out_instruction = headEntry.instr;
    assign out_result      = headEntry.result;
    assign out_store_data  = headEntry.storeData;
    assign out_rd          = headEntry.rd;
    assign out_pc          = headEntry.pc;
    assign out_mem_read    = headEntry.memRead;
    assign out_mem_write   = headEntry.memWrite;
    assign out_reg_write   = headEntry.regWrite;
    assign redirect_valid  = redirectValid_q;
    assign redirect_target = redirectTarget_q;

endmodule
